// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the RV32I decode stage.
//   - RV32I major opcode constants
//   - imm_src_t    : immediate format selector (I/S/B/U/J)
//   - result_src_t : writeback source select (ALU / memory / PC+4)
//   - alu_ctrl_t   : ALU operation encoding (0 = ADD)
//   - ctrl_bundle_t: every decoded control field carried down the pipe
//   - alu_op_decode: funct3 + alternate bit -> ALU operation
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_t;

  // ALU_PASS_B forwards operand B (LUI); ALU_ADD_PC tells execute to use
  // the PC as operand A (AUIPC).
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10,
    ALU_ADD_PC = 4'd11
  } alu_ctrl_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        illegal;
    result_src_t result_src;
    alu_ctrl_t   alu_ctrl;
  } ctrl_bundle_t;

  // alt selects SUB over ADD and SRA over SRL; other funct3 values ignore it.
  function automatic alu_ctrl_t alu_op_decode(input logic [2:0] funct3,
                                              input logic       alt);
    alu_ctrl_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: purely combinational RV32I control decoder and immediate
// extender.
//   instr   in  32          raw instruction
//   ctrl    out bundle      decoded control fields
//   imm_ext out DATA_WIDTH  sign-extended immediate for the instruction format
// R-type and unknown opcodes report the I-format immediate (unused downstream).
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  output ctrl_bundle_t          ctrl,
  output logic [DATA_WIDTH-1:0] imm_ext
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  imm_src_t    imm_src;

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    ctrl            = '0;
    ctrl.result_src = RES_ALU;
    ctrl.alu_ctrl   = ALU_ADD;
    imm_src         = IMM_I;
    case (opcode)
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_op_decode(funct3, instr[30]);
      end
      OPC_OP_IMM: begin
        // instr[30] is an immediate bit except for the SRAI/SRLI pair
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = alu_op_decode(funct3, (funct3 == 3'b101) && instr[30]);
      end
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
        imm_src       = IMM_B;
      end
      OPC_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      OPC_JALR: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_PASS_B;
        imm_src        = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD_PC;
        imm_src        = IMM_U;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

  // Size casts of the signed fields perform the sign extension.
  always_comb begin
    case (imm_src)
      IMM_I:   imm_ext = DATA_WIDTH'(imm_i);
      IMM_S:   imm_ext = DATA_WIDTH'(imm_s);
      IMM_B:   imm_ext = DATA_WIDTH'(imm_b);
      IMM_U:   imm_ext = DATA_WIDTH'(imm_u);
      IMM_J:   imm_ext = DATA_WIDTH'(imm_j);
      default: imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between fetch and execute.
//   clk, rst        clock, synchronous active-high reset
//   instr, pc       instruction and its PC from fetch, qualified by instr_valid
//   stall           downstream hold: pipeline register keeps its value
//   flush           squash: pipeline register loads a bubble
//   stall_req       combinational load-use hazard; fetch holds instr/pc
//   *_q             registered control, register indices, immediate and PC
//   illegal_q       registered instruction had an unsupported opcode
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     instr,
  input  logic [ADDR_WIDTH-1:0]     pc,
  input  logic                      instr_valid,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      stall_req,
  output logic                      valid_q,
  output logic                      RegWrite_q,
  output logic                      MemWrite_q,
  output logic                      MemRead_q,
  output logic                      ALUSrc_q,
  output logic                      Branch_q,
  output logic                      Jump_q,
  output logic [1:0]                ResultSrc_q,
  output logic [3:0]                ALUctrl_q,
  output logic [2:0]                funct3_q,
  output logic [REG_ADDR_WIDTH-1:0] rs1_q,
  output logic [REG_ADDR_WIDTH-1:0] rs2_q,
  output logic [REG_ADDR_WIDTH-1:0] rd_q,
  output logic [DATA_WIDTH-1:0]     ImmExt_q,
  output logic [ADDR_WIDTH-1:0]     pc_q,
  output logic                      illegal_q
);

  // ---- stage p0: combinational decode of the incoming instruction ----
  ctrl_bundle_t              ctrl_p0;
  logic [DATA_WIDTH-1:0]     imm_p0;
  logic [6:0]                opcode_p0;
  logic [REG_ADDR_WIDTH-1:0] rs1_p0;
  logic [REG_ADDR_WIDTH-1:0] rs2_p0;
  logic [REG_ADDR_WIDTH-1:0] rd_p0;
  logic                      uses_rs1_p0;
  logic                      uses_rs2_p0;

  decode_ctrl #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_decode_ctrl (
    .instr   (instr[31:0]),
    .ctrl    (ctrl_p0),
    .imm_ext (imm_p0)
  );

  assign opcode_p0 = instr[6:0];
  assign rd_p0     = instr[7 +: REG_ADDR_WIDTH];
  assign rs1_p0    = instr[15 +: REG_ADDR_WIDTH];
  assign rs2_p0    = instr[20 +: REG_ADDR_WIDTH];

  // Only fields the format really reads can create a dependency, so the
  // garbage in the rs1/rs2 slots of U/J types never stalls.
  assign uses_rs1_p0 = !((opcode_p0 == OPC_LUI) || (opcode_p0 == OPC_AUIPC) ||
                         (opcode_p0 == OPC_JAL));
  assign uses_rs2_p0 = (opcode_p0 == OPC_OP) || (opcode_p0 == OPC_STORE) ||
                       (opcode_p0 == OPC_BRANCH);

  // ---- stage p1: pipeline register ----
  ctrl_bundle_t              ctrl_p1;
  logic                      vld_p1;
  logic [2:0]                funct3_p1;
  logic [REG_ADDR_WIDTH-1:0] rs1_p1;
  logic [REG_ADDR_WIDTH-1:0] rs2_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_p1;
  logic [DATA_WIDTH-1:0]     imm_p1;
  logic [ADDR_WIDTH-1:0]     pc_p1;

  // Hazard looks at the registered load against the incoming reader; once
  // the bubble is in, vld_p1 is 0 and the request drops on its own.
  assign stall_req = vld_p1 && ctrl_p1.mem_read && (rd_p1 != '0) && instr_valid &&
                     ((uses_rs1_p0 && (rs1_p0 == rd_p1)) ||
                      (uses_rs2_p0 && (rs2_p0 == rd_p1)));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= '0;
      funct3_p1 <= '0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
      imm_p1    <= '0;
      pc_p1     <= '0;
    end else if (stall) begin
      vld_p1    <= vld_p1;
    end else if (stall_req || !instr_valid) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= '0;
      funct3_p1 <= '0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
      imm_p1    <= '0;
      pc_p1     <= '0;
    end else begin
      vld_p1    <= 1'b1;
      ctrl_p1   <= ctrl_p0;
      funct3_p1 <= instr[14:12];
      rs1_p1    <= rs1_p0;
      rs2_p1    <= rs2_p0;
      rd_p1     <= rd_p0;
      imm_p1    <= imm_p0;
      pc_p1     <= pc;
    end
  end

  assign valid_q     = vld_p1;
  assign RegWrite_q  = ctrl_p1.reg_write;
  assign MemWrite_q  = ctrl_p1.mem_write;
  assign MemRead_q   = ctrl_p1.mem_read;
  assign ALUSrc_q    = ctrl_p1.alu_src;
  assign Branch_q    = ctrl_p1.branch;
  assign Jump_q      = ctrl_p1.jump;
  assign illegal_q   = ctrl_p1.illegal;
  assign ResultSrc_q = ctrl_p1.result_src;
  assign ALUctrl_q   = ctrl_p1.alu_ctrl;
  assign funct3_q    = funct3_p1;
  assign rs1_q       = rs1_p1;
  assign rs2_q       = rs2_p1;
  assign rd_q        = rd_p1;
  assign ImmExt_q    = imm_p1;
  assign pc_q        = pc_p1;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered decode stage for the pipelined RV32I core, sitting between fetch and execute. It replaces the single-cycle combinational decoder with these capabilities:
- a parametrised pipeline register carrying decoded control, register addresses, immediate and PC;
- full immediate decoding (I/S/B/U/J);
- valid/stall/flush handling;
- load-use hazard detection that inserts a bubble.

Branch resolution (PCSrc) moves to execute; this block only flags branches and jumps.

## Interface

Parameters:
- DATA_WIDTH, 32, instruction and immediate width
- ADDR_WIDTH, 32, PC width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  DATA_WIDTH  instruction from fetch
- pc  in  ADDR_WIDTH  PC of instr
- instr_valid  in  1  instr/pc are meaningful
- stall  in  1  downstream hold; registers keep their value
- flush  in  1  squash; registers load a bubble
- stall_req  out  1  combinational load-use hazard; fetch must hold instr/pc
- valid_q  out  1  registered instruction is live
- RegWrite_q, MemWrite_q, MemRead_q, ALUSrc_q, Branch_q, Jump_q  out  1 each  registered control
- ResultSrc_q  out  2  0=ALU, 1=memory, 2=PC+4
- ALUctrl_q  out  4  ALU operation
- funct3_q  out  3  for branch compare and load/store size in execute
- rs1_q, rs2_q, rd_q  out  REG_ADDR_WIDTH  register indices
- ImmExt_q  out  DATA_WIDTH  sign-extended immediate
- pc_q  out  ADDR_WIDTH  PC of registered instruction
- illegal_q  out  1  unsupported opcode registered

## Operation

Combinational decode of `instr` produces the next control bundle.

Supported opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.

Immediate formats:
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U: {instr[31:12], 12'b0}
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- All are sign-extended to DATA_WIDTH.

Control by opcode:
- ALUctrl: from funct3 and instr[30]. instr[30] is honoured only for OP, and for OP-IMM when funct3=101.
- LUI: ALU passes the immediate, with ALUSrc=1.
- AUIPC: uses pc as operand A.
- JAL/JALR: Jump=1, ResultSrc=2, RegWrite=1.
- Unknown opcode: illegal=1; RegWrite, MemWrite, MemRead, Branch and Jump are all 0.

Load-use hazard (`stall_req`):
- stall_req=1 when all of the following hold: valid_q & MemRead_q, rd_q≠0, instr_valid, and the incoming instruction reads a register equal to rd_q.
- A register counts as read only if the format uses it: rs1 for all but LUI/AUIPC/JAL; rs2 for OP, STORE, BRANCH.

Register update priority each edge:
1. rst: everything cleared.
2. flush: load bubble.
3. stall: hold all registers.
4. stall_req: load bubble.
5. Otherwise: load the decoded bundle; valid_q=instr_valid.

A bubble means valid_q=0 and all write/read/branch/jump enables and illegal_q are 0. The other fields are don't-care but are cleared to 0.

When instr_valid=0 in the load case, the same bubble is loaded.

## Timing

- Latency: one cycle from instr to *_q.
- Reset value of every output: 0, including ImmExt_q, pc_q and ALUctrl_q (0 = ADD). stall_req also evaluates to 0 because valid_q=0.
- stall_req is purely combinational from instr and registered state, with no registered delay. A load followed immediately by a dependent instruction gives exactly one bubble cycle. On the next edge the load has left (valid_q=0 after the bubble), so stall_req drops.
- Simultaneous events:
  - flush with stall: flush wins.
  - flush with stall_req: flush wins; stall_req is still driven, which is harmless since fetch is redirected.
  - stall with stall_req: hold wins; the hazard persists and is re-evaluated next cycle.
- rst asserted mid-operation clears the registers on the same edge, regardless of stall or flush.
- rd=0 never triggers a hazard.

## Structure

- Shared package `decode_pkg`:
  - opcode constants;
  - `imm_src_t` (I, S, B, U, J);
  - `result_src_t`;
  - `alu_ctrl_t` encodings;
  - a `ctrl_bundle_t` struct of all control fields.
- Sub-module `decode_ctrl`: purely combinational (opcode/funct → ctrl_bundle_t, plus imm_src_t and the immediate extender).
- The top level `decode_stage` holds the hazard logic and the pipeline register.

## Test plan

- Reset: hold rst 2 cycles, then check every output = 0 and stall_req=0. Then assert rst mid-stream with stall=1 → all outputs = 0 next edge.
- addi x1,x0,5 (0x00500093), valid → next cycle:
  - valid_q=1, RegWrite_q=1, ALUSrc_q=1, rd_q=1, rs1_q=0, ImmExt_q=5, ALUctrl_q=ADD.
- sw x2,4(x1) (0x0020A223), then jal x1,8 (0x008000EF), then lui x5,0x12345 (0x123452B7):
  - sw: MemWrite_q=1, RegWrite_q=0, ImmExt_q=4.
  - jal: Jump_q=1, ResultSrc_q=2, ImmExt_q=8.
  - lui: ImmExt_q=0x12345000, rd_q=5.
- lw x2,0(x1) (0x0000A103), then add x3,x2,x1 (0x001101B3):
  - stall_req=1 for exactly one cycle, and a bubble is registered (valid_q=0).
  - The add then registers with valid_q=1.
  - Repeating with add x3,x0,x1 gives stall_req=0.
- Stall then flush:
  - addi registered, then stall=1 for 3 cycles → *_q unchanged.
  - flush=1 with stall=1 → valid_q=0, RegWrite_q=0 next edge.
- Opcode 0x7F: illegal_q=1, valid_q=1, all enables 0.
